// File: rtl/kong_throw_scheduler.sv
// Kong barrel-throw sequencer: WAIT/GET/HOLD/DROP cycle with lowest-free-slot spawn arbitration.
// Optional macro KONG_SCHED_RANDOM_EN adds an 8-bit LFSR jitter (0..15 cycles) to every wait load.
module kong_throw_scheduler #(
    parameter int SLOTS        = 4,
    parameter int THROW_PERIOD = 64,
    parameter int PHASE_LEN    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_over,
    input  logic [SLOTS-1:0]         i_slot_busy,
    input  logic                     i_spawn_ack,
    output logic                     o_spawn_req,
    output logic [$clog2(SLOTS)-1:0] o_spawn_slot,
    output logic [1:0]               o_animation_state,
    output logic                     o_playing,
    output logic [7:0]               o_throw_count
);

    localparam int SW = $clog2(SLOTS);
    localparam int TW = $clog2(THROW_PERIOD + 16);
    localparam int PW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GET,
        S_HOLD,
        S_DROP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [TW-1:0]   w_timer_load;
    logic [PW-1:0]   r_phase;
    logic [PW-1:0]   w_phase_nxt;
    logic            w_all_busy;
    logic [SW-1:0]   w_free_slot;
    logic            w_req_nxt;
    logic [SW-1:0]   w_slot_nxt;
    logic [1:0]      w_anim_nxt;
    logic            w_play_nxt;
    logic [7:0]      w_count_nxt;

`ifdef KONG_SCHED_RANDOM_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_timer_load = TW'(THROW_PERIOD - 1) + TW'(r_lfsr[3:0]);
`else
    assign w_timer_load = TW'(THROW_PERIOD - 1);
`endif

    // Downward scan so the lowest free index is the last one written
    always_comb begin
        w_all_busy  = &i_slot_busy;
        w_free_slot = '0;
        for (int unsigned i = SLOTS; i > 0; i--) begin
            if (!i_slot_busy[i-1]) begin
                w_free_slot = SW'(i - 1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_over) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_next = S_WAIT;
                S_WAIT:  if (r_timer == '0 && !w_all_busy) w_next = S_GET;
                S_GET:   if (r_phase == '0) w_next = S_HOLD;
                S_HOLD:  if (r_phase == '0) w_next = S_DROP;
                S_DROP:  if (i_spawn_ack) w_next = S_WAIT;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_timer_nxt = r_timer;
        w_phase_nxt = r_phase;

        if ((r_state == S_IDLE || r_state == S_DROP) && w_next == S_WAIT) begin
            w_timer_nxt = w_timer_load;
        end else if (r_state == S_WAIT && r_timer != '0) begin
            w_timer_nxt = r_timer - 1'b1;
        end

        if ((w_next == S_GET && r_state != S_GET) || (w_next == S_HOLD && r_state != S_HOLD)) begin
            w_phase_nxt = PW'(PHASE_LEN - 1);
        end else if ((r_state == S_GET || r_state == S_HOLD) && r_phase != '0) begin
            w_phase_nxt = r_phase - 1'b1;
        end
    end

    // Outputs are registered from the next state, so they change on the same edge as the state
    always_comb begin
        case (w_next)
            S_GET:   w_anim_nxt = 2'b01;
            S_HOLD:  w_anim_nxt = 2'b10;
            S_DROP:  w_anim_nxt = 2'b11;
            default: w_anim_nxt = 2'b00;
        endcase
        w_play_nxt  = (w_next != S_IDLE);
        w_req_nxt   = (w_next == S_DROP);
        w_slot_nxt  = (r_state == S_WAIT && w_next == S_GET) ? w_free_slot : o_spawn_slot;
        w_count_nxt = o_throw_count;
        if (r_state == S_IDLE && w_next == S_WAIT) begin
            w_count_nxt = '0;
        end else if (r_state == S_DROP && w_next == S_WAIT && o_throw_count != '1) begin
            w_count_nxt = o_throw_count + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer           <= '0;
            r_phase           <= '0;
            o_spawn_req       <= 1'b0;
            o_spawn_slot      <= '0;
            o_animation_state <= 2'b00;
            o_playing         <= 1'b0;
            o_throw_count     <= '0;
        end else begin
            r_timer           <= w_timer_nxt;
            r_phase           <= w_phase_nxt;
            o_spawn_req       <= w_req_nxt;
            o_spawn_slot      <= w_slot_nxt;
            o_animation_state <= w_anim_nxt;
            o_playing         <= w_play_nxt;
            o_throw_count     <= w_count_nxt;
        end
    end

endmodule

// File: doc/kong_throw_scheduler.md
# kong_throw_scheduler

Sequences Kong's barrel-throw cycle during play and allocates barrel slots from a fixed pool. Sits between the game-state logic (`start`/`over`) and the barrel instances. Drives Kong's animation phase (normal/get/hold/drop) and issues one spawn request per throw to the lowest free barrel slot, using a req/ack handshake.

## Interface
- `SLOTS`, 4: number of barrel slots, 2..8.
- `THROW_PERIOD`, 64: cycles spent in WAIT between throws, at least 2.
- `PHASE_LEN`, 2: cycles spent in each of GET and HOLD, at least 1.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  game start; sampled only in IDLE.
- `over`  in  1  game over; forces IDLE from any state.
- `slot_busy`  in  SLOTS  bit i high means barrel slot i is active.
- `spawn_ack`  in  1  barrel slot accepted the spawn; single-cycle pulse.
- `spawn_req`  out  1  spawn request, held high until acknowledged.
- `spawn_slot`  out  $clog2(SLOTS)  target slot; stable while `spawn_req` is high.
- `animation_state`  out  2  encoding: 00 NORMAL, 01 GET, 10 HOLD, 11 DROP.
- `playing`  out  1  high in every state except IDLE.
- `throw_count`  out  8  throws completed since the last start; saturates at 255.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE.
  - `spawn_req`=0, `spawn_slot`=0, `animation_state`=00, `playing`=0, `throw_count`=0.
  - Timer=0, phase counter=0.
- IDLE: `animation_state`=NORMAL.
  - If `start` & ~`over`: go to WAIT, load timer with THROW_PERIOD-1, clear `throw_count`.
- WAIT: timer decrements once per cycle.
  - When timer==0 and `slot_busy` is not all ones: go to GET.
  - Latch `spawn_slot` to the lowest-index zero bit of `slot_busy`.
  - When timer==0 and all slots are busy: stay in WAIT with the timer held at 0 (stall).
- GET: `animation_state`=01 for PHASE_LEN cycles, then go to HOLD.
- HOLD: `animation_state`=10 for PHASE_LEN cycles, then go to DROP.
- DROP: `animation_state`=11 and `spawn_req`=1.
  - On the cycle `spawn_ack` is sampled high: `spawn_req` falls, `throw_count` increments (saturating), timer reloads, go to WAIT.
- WAIT `animation_state`=NORMAL.
- `spawn_ack` is ignored while `spawn_req`=0.
- `over`=1 in any non-IDLE state wins over every other transition, including a simultaneous `spawn_ack`.
  - Next state is IDLE, `spawn_req`=0, `animation_state`=NORMAL.
  - `throw_count` holds its value and is not incremented by the simultaneous ack.
- `start` outside IDLE is ignored. `start` and `over` high together in IDLE: remain in IDLE.
- The latched `spawn_slot` is not re-arbitrated during GET/HOLD/DROP. Slots become busy only through this block's spawns.

## Timing
- `start` sampled at edge N → at edge N: `playing`=1 and state=WAIT.
- First GET at edge N+THROW_PERIOD when slots are free.
- GET and HOLD each last exactly PHASE_LEN cycles.
- `spawn_req` rises at the same edge DROP is entered.
- Minimum DROP length: 1 cycle (ack on the first DROP cycle).
- Throw-to-throw spacing with an immediate ack and no stall: THROW_PERIOD + 2·PHASE_LEN + 1 cycles.
- Reset mid-operation: all outputs go to their reset values asynchronously. An in-flight request is abandoned with no ack needed.

## Configuration
- `KONG_SCHED_RANDOM_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - Every timer load (start and post-ack reload) uses THROW_PERIOD-1+lfsr[3:0].
- Not defined: no LFSR is instantiated; every load is exactly THROW_PERIOD-1.

## Test plan
- Fixed period, no slots busy, defaults, ack one cycle after req:
  - Pulse `start` → GET entered 64 cycles after start, 2 cycles GET, 2 cycles HOLD, DROP with `spawn_slot`=0.
  - After ack, `throw_count`=1; second GET follows 69 cycles after the first.
- `slot_busy`=4'b1011 → `spawn_slot`=2.
  - `slot_busy`=4'b1111 at timer expiry → stall in WAIT, `animation_state`=00.
  - Set `slot_busy`=4'b0111 → GET on the next cycle with `spawn_slot`=3.
- Withhold ack for 10 cycles in DROP → `spawn_req` and `spawn_slot` stay constant and `animation_state`=11 throughout.
  - Ack → `spawn_req`=0 on the next edge.
- `over` and `spawn_ack` together in DROP → IDLE, `spawn_req`=0, `throw_count` unchanged.
  - A later `start` clears `throw_count` to 0.
- Assert `rst` asynchronously mid-HOLD → all outputs are at reset values before the next clock edge.
  - `start` during reset has no effect.
- With `KONG_SCHED_RANDOM_EN`: wait lengths follow the LFSR sequence from seed 8'hA5 and are each within 64..79 cycles.
  - Run 300 throws → `throw_count` saturates at 255.
